// File: rtl/mul_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_ctrl_pkg
// Purpose  : Shared widths, the pipeline tracking entry type and a constant
//            clog2 helper for the multiplier issue/completion controller.
// Revision : 1.0 - initial release
// ============================================================================
package mul_ctrl_pkg;

    localparam int DEF_TAG_W = 4;   // default destination tag width
    localparam int WORD_W    = 32;  // operand / CDB data width
    localparam int PROD_W    = 64;  // full datapath product width

    // The tracking entry carries the tag in a field wide enough for any
    // reasonable TAG_W; the controller narrows it back when writing the buffer.
    localparam int TRK_TAG_W = 16;

    typedef struct packed {
        logic                 valid;
        logic [TRK_TAG_W-1:0] tag;
    } trk_entry_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter with a combinational one-hot grant. The
//            search starts at the pointer and wraps; the pointer advances to
//            one past the winner and holds when nothing is granted.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mul_ctrl_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;
    logic [PW-1:0] sel_hi;
    logic [PW-1:0] sel_lo;
    logic          hit_hi;
    logic          hit_lo;

    // Lowest requester at/above the pointer wins; otherwise the lowest overall.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        sel_hi = '0;
        sel_lo = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                hit_lo = 1'b1;
                sel_lo = PW'(i);
                if (PW'(i) >= ptr) begin
                    hit_hi = 1'b1;
                    sel_hi = PW'(i);
                end
            end
        end
        sel = hit_hi ? sel_hi : sel_lo;
        for (int i = 0; i < N; i++) begin
            gnt[i] = en & hit_lo & (sel == PW'(i));
        end
    end

    // Pointer moves one past the granted station, wrapping at N.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_issue_ctrl
// Purpose  : Issue/completion controller for the fixed-latency multiplier.
//            Round-robin issue from the reservation stations, tag tracking
//            alongside the datapath, and a result FIFO feeding the CDB.
//            A credit counter (in flight + buffered) guarantees the
//            non-stallable datapath always has a free buffer slot.
//            Optional macro MUL_FLUSH_EN adds a 'flush' input.
// Revision : 1.0 - initial release
// ============================================================================
module mul_issue_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int NUM_RS    = 3,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int MUL_LAT   = 2,
    parameter int RES_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef MUL_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic [NUM_RS-1:0]          rs_req,
    output logic [NUM_RS-1:0]          rs_grant,
    input  logic [NUM_RS*TAG_W-1:0]    rs_tag,
    input  logic [NUM_RS*WORD_W-1:0]   rs_opa,
    input  logic [NUM_RS*WORD_W-1:0]   rs_opb,
    output logic                       mul_start,
    output logic [WORD_W-1:0]          mul_a,
    output logic [WORD_W-1:0]          mul_b,
    input  logic [PROD_W-1:0]          mul_prod,
    output logic                       cdb_req,
    input  logic                       cdb_gnt,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [WORD_W-1:0]          cdb_data,
    output logic                       busy
);

    localparam int AW = clog2(RES_DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = clog2(RES_DEPTH + 1);

    logic                do_flush;
    logic [CW-1:0]       cnt;
    logic [OW-1:0]       occ;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [TAG_W-1:0]    tag_mem  [RES_DEPTH];
    logic [WORD_W-1:0]   data_mem [RES_DEPTH];
    logic [TAG_W-1:0]    launch_tag;
    trk_entry_t          trk      [MUL_LAT];
    logic                arb_en;
    logic                grant;
    logic                pop;
    logic                wr_en;
    logic                full;
    logic [TAG_W-1:0]    sel_tag;
    logic [WORD_W-1:0]   sel_a;
    logic [WORD_W-1:0]   sel_b;
    logic                unused_prod_hi;
    logic                unused_trk_hi;

`ifdef MUL_FLUSH_EN
    assign do_flush = flush;
`else
    assign do_flush = 1'b0;
`endif

    assign cdb_req  = (occ != '0);
    assign full     = (occ == OW'(RES_DEPTH));
    assign pop      = cdb_req & cdb_gnt & ~do_flush;
    // A pop in the same cycle frees the credit the new grant consumes.
    assign arb_en   = ~rst & ~do_flush & ((cnt < CW'(RES_DEPTH)) | pop);
    assign grant    = |rs_grant;
    assign wr_en    = trk[MUL_LAT-1].valid & ~do_flush;
    assign cdb_tag  = tag_mem[rd_ptr];
    assign cdb_data = data_mem[rd_ptr];
    assign busy     = (cnt != '0);

    // Only the low word of the product is broadcast; spare tag bits are zero.
    assign unused_prod_hi = ^mul_prod[PROD_W-1:WORD_W];
    assign unused_trk_hi  = |(trk[MUL_LAT-1].tag >> TAG_W);

    rr_arbiter #(
        .N   (NUM_RS)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (rs_req),
        .en  (arb_en),
        .gnt (rs_grant)
    );

    // One-hot operand/tag mux driven by the grant.
    always_comb begin
        sel_tag = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (rs_grant[i]) begin
                sel_tag = sel_tag | rs_tag[i*TAG_W +: TAG_W];
                sel_a   = sel_a   | rs_opa[i*WORD_W +: WORD_W];
                sel_b   = sel_b   | rs_opb[i*WORD_W +: WORD_W];
            end
        end
    end

    // Launch registers: operands hold between launches.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            launch_tag <= '0;
        end else begin
            mul_start <= grant;
            if (grant) begin
                mul_a      <= sel_a;
                mul_b      <= sel_b;
                launch_tag <= sel_tag;
            end
        end
    end

    // Tag tracker: stage MUL_LAT-1 is valid in the cycle the product arrives.
    always_ff @(posedge clk) begin
        if (rst || do_flush) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                trk[i] <= '0;
            end
        end else begin
            trk[0] <= '{valid: mul_start, tag: TRK_TAG_W'(launch_tag)};
            for (int i = 1; i < MUL_LAT; i++) begin
                trk[i] <= trk[i-1];
            end
        end
    end

    // Credit counter: grant and pop in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst || do_flush) begin
            cnt <= '0;
        end else if (grant && !pop) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !grant) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Result FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                occ <= occ + OW'(1);
            end else if (pop && !wr_en) begin
                occ <= occ - OW'(1);
            end
        end
    end

    // Result FIFO storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_ptr]  <= TAG_W'(trk[MUL_LAT-1].tag);
            data_mem[wr_ptr] <= mul_prod[WORD_W-1:0];
        end
    end

    // Credits must make a write into a full, non-draining buffer impossible.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            assert (!full || pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_issue_ctrl
// Purpose  : Self-checking bench for mul_issue_ctrl. A queue-based model
//            (in-flight list + result list) predicts every cycle's outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_issue_ctrl;

    localparam int NUM_RS    = 3;
    localparam int TAG_W     = 4;
    localparam int MUL_LAT   = 2;
    localparam int RES_DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic [NUM_RS-1:0]       rs_req;
    logic [NUM_RS-1:0]       rs_grant;
    logic [NUM_RS*TAG_W-1:0] rs_tag;
    logic [NUM_RS*32-1:0]    rs_opa;
    logic [NUM_RS*32-1:0]    rs_opb;
    logic                    mul_start;
    logic [31:0]             mul_a;
    logic [31:0]             mul_b;
    logic [63:0]             mul_prod;
    logic                    cdb_req;
    logic                    cdb_gnt;
    logic [TAG_W-1:0]        cdb_tag;
    logic [31:0]             cdb_data;
    logic                    busy;

    always #5 clk = ~clk;

    mul_issue_ctrl #(
        .NUM_RS    (NUM_RS),
        .TAG_W     (TAG_W),
        .MUL_LAT   (MUL_LAT),
        .RES_DEPTH (RES_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MUL_FLUSH_EN
        .flush     (flush),
`endif
        .rs_req    (rs_req),
        .rs_grant  (rs_grant),
        .rs_tag    (rs_tag),
        .rs_opa    (rs_opa),
        .rs_opb    (rs_opb),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_prod  (mul_prod),
        .cdb_req   (cdb_req),
        .cdb_gnt   (cdb_gnt),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .busy      (busy)
    );

    // Multiplier datapath: product appears MUL_LAT cycles after mul_start,
    // random junk otherwise. It is never reset, so stale products survive.
    logic [63:0] dp [MUL_LAT];
    always @(posedge clk) begin
        dp[0] <= mul_start ? (64'(mul_a) * 64'(mul_b)) : {$urandom, $urandom};
        for (int i = 1; i < MUL_LAT; i++) dp[i] <= dp[i-1];
    end
    assign mul_prod = dp[MUL_LAT-1];

    // Reference model state
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        int               ready;
    } op_t;

    op_t         inflight[$];
    op_t         rbuf[$];
    int          ptr;
    int          cyc;
    logic        exp_start;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int          dut_log[$];

    // Requesting stations
    logic             pend   [NUM_RS];
    logic [TAG_W-1:0] st_tag [NUM_RS];
    logic [31:0]      st_a   [NUM_RS];
    logic [31:0]      st_b   [NUM_RS];

    // Samples from the most recent cycle
    logic [NUM_RS-1:0] s_grant;
    logic              s_start;
    logic              s_cdb_req;
    logic [TAG_W-1:0]  s_cdb_tag;
    logic [31:0]       s_cdb_data;
    logic              s_busy;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_RS; i++) begin
            rs_req[i]                 = pend[i];
            rs_tag[i*TAG_W +: TAG_W]  = st_tag[i];
            rs_opa[i*32 +: 32]        = st_a[i];
            rs_opb[i*32 +: 32]        = st_b[i];
        end
    endtask

    task automatic set_op(input int s, input logic [TAG_W-1:0] t, input logic [31:0] a, input logic [31:0] b);
        pend[s] = 1'b1; st_tag[s] = t; st_a[s] = a; st_b[s] = b;
    endtask

    task automatic refill(input int pct);
        for (int i = 0; i < NUM_RS; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < pct) begin
                set_op(i, TAG_W'($urandom), $urandom, $urandom);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_RS; i++) pend[i] = 1'b0;
        drive();
        cdb_gnt = 1'b0;
        flush   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        inflight.delete();
        rbuf.delete();
        ptr = 0; exp_start = 1'b0; exp_a = '0; exp_b = '0;
        cyc++;
    endtask

    // One clock cycle: drive, predict, compare at mid-cycle, then advance model.
    task automatic tick(input logic gin, input logic fl);
        int   g;
        int   occ;
        logic pop;
        logic room;
        drive();
        cdb_gnt = gin;
        flush   = fl;
        #4;
        occ  = inflight.size() + rbuf.size();
        pop  = !fl && gin && (rbuf.size() > 0);
        room = !fl && ((occ < RES_DEPTH) || pop);
        g = -1;
        if (room) begin
            for (int k = 0; k < NUM_RS; k++) begin
                if (g < 0 && pend[(ptr + k) % NUM_RS]) g = (ptr + k) % NUM_RS;
            end
        end
        s_grant = rs_grant; s_start = mul_start; s_cdb_req = cdb_req;
        s_cdb_tag = cdb_tag; s_cdb_data = cdb_data; s_busy = busy;
        chk("rs_grant", rs_grant, (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("cdb_req", cdb_req, rbuf.size() > 0);
        if (rbuf.size() > 0) begin
            chk("cdb_tag", cdb_tag, rbuf[0].tag);
            chk("cdb_data", cdb_data, rbuf[0].data);
        end
        chk("mul_start", mul_start, exp_start);
        chk("mul_a", mul_a, exp_a);
        chk("mul_b", mul_b, exp_b);
        chk("busy", busy, occ != 0);
        for (int i = 0; i < NUM_RS; i++) if (rs_grant[i]) dut_log.push_back(i);
        @(posedge clk);
        if (fl) begin
            inflight.delete();
            rbuf.delete();
            exp_start = 1'b0;
        end else begin
            if (pop) void'(rbuf.pop_front());
            while (inflight.size() > 0 && inflight[0].ready == cyc) rbuf.push_back(inflight.pop_front());
            exp_start = (g >= 0);
            if (g >= 0) begin
                inflight.push_back('{tag: st_tag[g], data: st_a[g] * st_b[g], ready: cyc + 1 + MUL_LAT});
                exp_a = st_a[g]; exp_b = st_b[g];
                pend[g] = 1'b0;
                ptr = (g + 1) % NUM_RS;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        cyc = 0;
        for (int i = 0; i < NUM_RS; i++) set_op(i, '0, '0, '0);
        do_reset();
        do_reset();

        // Reset values, then a single operation 7*6 with tag 5 from station 1
        tick(1'b0, 1'b0);
        set_op(1, 4'd5, 32'd7, 32'd6);
        tick(1'b0, 1'b0);
        chk("single_grant", s_grant, 3'b010);
        tick(1'b0, 1'b0);
        chk("single_start", s_start, 1'b1);
        tick(1'b0, 1'b0);
        chk("single_no_early_req", s_cdb_req, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        chk("single_req", s_cdb_req, 1'b1);
        chk("single_tag", s_cdb_tag, 4'd5);
        chk("single_data", s_cdb_data, 32'd42);
        tick(1'b0, 1'b0);
        chk("single_busy_drop", s_busy, 1'b0);

        // Round-robin with all stations re-raising and CDB always granting
        do_reset();
        dut_log.delete();
        for (int n = 0; n < 6; n++) begin
            refill(100);
            tick(1'b1, 1'b0);
        end
        chk("rr_count", dut_log.size(), 6);
        for (int n = 0; n < 6; n++) begin
            if (n < dut_log.size()) chk("rr_order", dut_log[n], n % 3);
        end

        // Backpressure: no CDB grant, exactly RES_DEPTH issues
        do_reset();
        dut_log.delete();
        for (int n = 0; n < 8; n++) begin
            refill(100);
            tick(1'b0, 1'b0);
        end
        chk("bp_grants", dut_log.size(), RES_DEPTH);
        chk("bp_blocked", s_grant, 3'b000);
        refill(100);
        tick(1'b1, 1'b0);
        chk("bp_release", $countones(s_grant), 1);
        refill(100);
        tick(1'b0, 1'b0);
        chk("bp_reblock", s_grant, 3'b000);

        // Full boundary: pop and issue every cycle while at full credit
        for (int n = 0; n < 16; n++) begin
            refill(100);
            tick(1'b1, 1'b0);
            chk("full_busy", s_busy, 1'b1);
        end

        // Random soak
        for (int n = 0; n < 300; n++) begin
            refill(int'($urandom_range(20, 90)));
`ifdef MUL_FLUSH_EN
            tick(1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
`else
            tick(1'($urandom_range(0, 1)), 1'b0);
`endif
        end

        // Reset one cycle after mul_start; the stale product must vanish
        do_reset();
        set_op(1, 4'd9, 32'd3, 32'd3);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rst_mid_start", s_start, 1'b1);
        do_reset();
        set_op(0, 4'd1, 32'd2, 32'd5);
        set_op(2, 4'd2, 32'd4, 32'd4);
        tick(1'b0, 1'b0);
        chk("rst_ptr_grant", s_grant, 3'b001);
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_start", s_start, 1'b0);
        for (int n = 0; n < 8; n++) tick(1'b1, 1'b0);

`ifdef MUL_FLUSH_EN
        // Flush with one buffered and two in flight
        do_reset();
        set_op(0, 4'd3, 32'd10, 32'd10);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        set_op(1, 4'd4, 32'd11, 32'd2);
        tick(1'b0, 1'b0);
        set_op(2, 4'd6, 32'd12, 32'd3);
        tick(1'b0, 1'b0);
        set_op(0, 4'd7, 32'd5, 32'd5);
        tick(1'b0, 1'b1);
        chk("flush_pre_req", s_cdb_req, 1'b1);
        chk("flush_no_grant", s_grant, 3'b000);
        tick(1'b0, 1'b0);
        chk("flush_cdb_req", s_cdb_req, 1'b0);
        chk("flush_busy", s_busy, 1'b0);
        chk("flush_regrant", s_grant, 3'b001);
        for (int n = 0; n < 8; n++) tick(1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
